// File: rtl/alu_issue_pipe.sv
// alu_issue_pipe: issue/execute/writeback back-end with a register file,
// a fixed-depth result pipeline, optional full bypass or scoreboard
// interlock, flush support and a retire counter.
module alu_issue_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int STAGES = 3,
  parameter int FWD    = 1,
  localparam int RW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_aluctr,
  input  logic [RW-1:0]   in_rs,
  input  logic [RW-1:0]   in_rt,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_use_imm,
  input  logic [15:0]     in_imm,
  input  logic            flush,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     retire_cnt,
  input  logic [RW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] rf_q   [NREG];
  logic            pv_q   [STAGES];
  logic [RW-1:0]   prd_q  [STAGES];
  logic [XLEN-1:0] pres_q [STAGES];
  logic [31:0]     retire_q;
  logic [31:0]     retire_d;

  logic [XLEN-1:0] rs_rf;
  logic [XLEN-1:0] rt_rf;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b_reg;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] alu_res;
  logic            hazard;
  logic            issue;

  // Writeback mirrors the last pipeline stage; a flush suppresses it.
  always_comb begin
    wb_valid   = pv_q[STAGES-1] && !flush;
    wb_rd      = prd_q[STAGES-1];
    wb_data    = pres_q[STAGES-1];
    retire_cnt = retire_q;
    dbg_data   = rf_q[dbg_addr];
    retire_d   = wb_valid ? retire_q + 32'd1 : retire_q;
  end

  // Operand resolution: write-through register read, then bypass or hazard detection.
  always_comb begin
    rs_rf    = (wb_valid && wb_rd == in_rs) ? wb_data : rf_q[in_rs];
    rt_rf    = (wb_valid && wb_rd == in_rt) ? wb_data : rf_q[in_rt];
    op_a     = rs_rf;
    op_b_reg = rt_rf;
    hazard   = 1'b0;
    if (FWD != 0) begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (pv_q[k] && prd_q[k] == in_rs) op_a = pres_q[k];
        if (pv_q[k] && prd_q[k] == in_rt) op_b_reg = pres_q[k];
      end
    end else begin
      for (int k = 0; k < STAGES - 1; k++) begin
        if (pv_q[k] && prd_q[k] == in_rs && in_rs != '0) hazard = 1'b1;
        if (pv_q[k] && prd_q[k] == in_rt && in_rt != '0 && !in_use_imm) hazard = 1'b1;
      end
    end
    if (in_rs == '0) op_a = '0;
    if (in_rt == '0) op_b_reg = '0;
    imm_sext = XLEN'($signed(in_imm));
    op_b     = in_use_imm ? imm_sext : op_b_reg;
  end

  // ALU evaluated at issue, plus the handshake decision.
  always_comb begin
    alu_res = '0;
    case (in_aluctr)
      3'b000:  alu_res = op_a + op_b;
      3'b001:  alu_res = op_a - op_b;
      3'b010:  alu_res = op_a & op_b;
      3'b011:  alu_res = op_a | op_b;
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b110:  alu_res = op_a << op_b[SW-1:0];
      default: alu_res = ~(op_a | op_b);
    endcase
    in_ready = rst && (flush || (FWD != 0) || !hazard);
    issue    = in_valid && in_ready && !flush;
  end

  // Result pipeline: shifts every cycle, bubbles on no issue, cleared by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        pv_q[k]   <= 1'b0;
        prd_q[k]  <= '0;
        pres_q[k] <= '0;
      end
    end else begin
      pv_q[0]   <= issue;
      prd_q[0]  <= in_rd;
      pres_q[0] <= alu_res;
      for (int k = 1; k < STAGES; k++) begin
        pv_q[k]   <= pv_q[k-1];
        prd_q[k]  <= prd_q[k-1];
        pres_q[k] <= pres_q[k-1];
      end
      if (flush) begin
        for (int k = 0; k < STAGES; k++) pv_q[k] <= 1'b0;
      end
    end
  end

  // Register file write and retire counting at the end of a writeback cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
      if (wb_valid && wb_rd != '0) rf_q[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_alu_issue_pipe.sv
// tb_alu_issue_pipe: drives one bypassing and one interlocked instance with
// the same op programs and checks both against a program-order model.
module tb_alu_issue_pipe;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int STAGES = 3;
  localparam int NSLOT  = 16;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [2:0]  ctr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        use_imm;
    logic [15:0] imm;
  } op_t;

  logic        clk;
  logic        rst;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [2:0]  in_aluctr  [2];
  logic [4:0]  in_rs      [2];
  logic [4:0]  in_rt      [2];
  logic [4:0]  in_rd      [2];
  logic        in_use_imm [2];
  logic [15:0] in_imm     [2];
  logic        flush      [2];
  logic        wb_valid   [2];
  logic [4:0]  wb_rd      [2];
  logic [31:0] wb_data    [2];
  logic [31:0] retire_cnt [2];
  logic [4:0]  dbg_addr   [2];
  logic [31:0] dbg_data   [2];

  int tests;
  int failures;

  // program shared by both instances, each consuming at its own pace
  op_t  prog [$];
  int   pidx [2];
  logic busy [2];
  op_t  cur  [2];
  int   stall[2];
  int   cyc;

  // architectural model: committed registers plus in-flight results with due cycle
  logic [31:0] mrf  [2][NREG];
  logic        pv   [2][NSLOT];
  logic [4:0]  prd  [2][NSLOT];
  logic [31:0] pres [2][NSLOT];
  int          pdue [2][NSLOT];
  int          mret [2];

  alu_issue_pipe #(.XLEN(XLEN), .NREG(NREG), .STAGES(STAGES), .FWD(1)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_aluctr(in_aluctr[0]),
    .in_rs(in_rs[0]), .in_rt(in_rt[0]), .in_rd(in_rd[0]),
    .in_use_imm(in_use_imm[0]), .in_imm(in_imm[0]), .flush(flush[0]),
    .wb_valid(wb_valid[0]), .wb_rd(wb_rd[0]), .wb_data(wb_data[0]),
    .retire_cnt(retire_cnt[0]), .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0])
  );

  alu_issue_pipe #(.XLEN(XLEN), .NREG(NREG), .STAGES(STAGES), .FWD(0)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_aluctr(in_aluctr[1]),
    .in_rs(in_rs[1]), .in_rt(in_rt[1]), .in_rd(in_rd[1]),
    .in_use_imm(in_use_imm[1]), .in_imm(in_imm[1]), .flush(flush[1]),
    .wb_valid(wb_valid[1]), .wb_rd(wb_rd[1]), .wb_data(wb_data[1]),
    .retire_cnt(retire_cnt[1]), .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic op_t mkOp(input logic v, input logic f, input logic [2:0] c,
                               input logic [4:0] s, input logic [4:0] t,
                               input logic [4:0] d, input logic ui,
                               input logic [15:0] im);
    op_t o;
    o.valid = v; o.flush = f; o.ctr = c; o.rs = s; o.rt = t; o.rd = d;
    o.use_imm = ui; o.imm = im;
    return o;
  endfunction

  function automatic logic [4:0] pickReg();
    if ($urandom_range(0, 9) < 7) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic op_t randOp();
    op_t o;
    o.valid   = ($urandom_range(0, 9) < 8);
    o.flush   = ($urandom_range(0, 24) == 0);
    o.ctr     = 3'($urandom_range(0, 7));
    o.rs      = pickReg();
    o.rt      = pickReg();
    o.rd      = pickReg();
    o.use_imm = ($urandom_range(0, 1) == 1);
    o.imm     = 16'($urandom());
    return o;
  endfunction

  function automatic logic [31:0] aluRef(input logic [2:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return ~(a | b);
    endcase
  endfunction

  // value register idx holds in program order: latest pending producer, else committed
  function automatic logic [31:0] operandRef(input int d, input logic [4:0] idx);
    logic [31:0] val;
    int best;
    if (idx == 5'd0) return 32'd0;
    val  = mrf[d][idx];
    best = -1;
    for (int s = 0; s < NSLOT; s++) begin
      if (pv[d][s] && prd[d][s] == idx && pdue[d][s] > best) begin
        best = pdue[d][s];
        val  = pres[d][s];
      end
    end
    return val;
  endfunction

  task automatic driveOp(input int d, input op_t o);
    in_valid[d]   = o.valid;
    flush[d]      = o.flush;
    in_aluctr[d]  = o.ctr;
    in_rs[d]      = o.rs;
    in_rt[d]      = o.rt;
    in_rd[d]      = o.rd;
    in_use_imm[d] = o.use_imm;
    in_imm[d]     = o.imm;
  endtask

  task automatic modelCycle(input int d);
    logic        hazard;
    logic        expReady;
    logic        expWb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          wbSlot;
    op_t         o;
    o      = cur[d];
    hazard = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      if (pv[d][s] && pdue[d][s] > cyc && prd[d][s] != 5'd0) begin
        if (prd[d][s] == o.rs) hazard = 1'b1;
        if (!o.use_imm && prd[d][s] == o.rt) hazard = 1'b1;
      end
    end
    expReady = (d == 0) || o.flush || !hazard;
    checkOutput($sformatf("dut%0d_ready", d), 32'(in_ready[d]), 32'(expReady));
    if (o.valid && !in_ready[d]) stall[d]++;

    wbSlot = -1;
    for (int s = 0; s < NSLOT; s++)
      if (pv[d][s] && pdue[d][s] == cyc) wbSlot = s;
    expWb = (wbSlot >= 0) && !o.flush;
    checkOutput($sformatf("dut%0d_wb_valid", d), 32'(wb_valid[d]), 32'(expWb));
    if (expWb) begin
      checkOutput($sformatf("dut%0d_wb_rd", d), 32'(wb_rd[d]), 32'(prd[d][wbSlot]));
      checkOutput($sformatf("dut%0d_wb_data", d), wb_data[d], pres[d][wbSlot]);
    end
    checkOutput($sformatf("dut%0d_retire", d), retire_cnt[d], 32'(mret[d]));
    checkOutput($sformatf("dut%0d_dbg", d), dbg_data[d], mrf[d][dbg_addr[d]]);

    a   = operandRef(d, o.rs);
    b   = o.use_imm ? {{16{o.imm[15]}}, o.imm} : operandRef(d, o.rt);
    res = aluRef(o.ctr, a, b);

    if (o.flush) begin
      for (int s = 0; s < NSLOT; s++) pv[d][s] = 1'b0;
    end else if (wbSlot >= 0) begin
      if (prd[d][wbSlot] != 5'd0) mrf[d][prd[d][wbSlot]] = pres[d][wbSlot];
      mret[d]++;
      pv[d][wbSlot] = 1'b0;
    end

    if (o.valid && expReady && !o.flush) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (!pv[d][s]) begin
          pv[d][s]   = 1'b1;
          prd[d][s]  = o.rd;
          pres[d][s] = res;
          pdue[d][s] = cyc + STAGES;
          break;
        end
      end
    end

    if (busy[d] && (!o.valid || expReady)) begin
      busy[d] = 1'b0;
      pidx[d]++;
    end
  endtask

  // one clock cycle: present inputs at the falling edge, check, advance the model
  task automatic applyStimulus();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!busy[d] && pidx[d] < prog.size()) begin
        cur[d]  = prog[pidx[d]];
        busy[d] = 1'b1;
      end
      if (!busy[d]) cur[d] = mkOp(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 16'd0);
      driveOp(d, cur[d]);
      dbg_addr[d] = 5'($urandom_range(0, 15));
    end
    #1;
    for (int d = 0; d < 2; d++) modelCycle(d);
    cyc++;
  endtask

  task automatic runProgram(input bit drain);
    int guard;
    guard = 0;
    pidx[0] = 0;
    pidx[1] = 0;
    while ((pidx[0] < prog.size() || busy[0] || pidx[1] < prog.size() || busy[1])
           && guard < 20000) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 20000) checkOutput("program_timeout", 32'd0, 32'd1);
    if (drain) repeat (STAGES + 1) applyStimulus();
  endtask

  task automatic peekReg(input int d, input logic [4:0] addr, input logic [31:0] expected,
                         input string tag);
    @(posedge clk);
    dbg_addr[d] = addr;
    #1;
    checkOutput($sformatf("dut%0d_%s", d, tag), dbg_data[d], expected);
  endtask

  task automatic clearModel();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NREG; i++) mrf[d][i] = 32'd0;
      for (int s = 0; s < NSLOT; s++) begin
        pv[d][s] = 1'b0; prd[d][s] = 5'd0; pres[d][s] = 32'd0; pdue[d][s] = 0;
      end
      mret[d]  = 0;
      busy[d]  = 1'b0;
      pidx[d]  = 0;
      stall[d] = 0;
      cur[d]   = mkOp(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 16'd0);
      driveOp(d, cur[d]);
      dbg_addr[d] = 5'd1;
    end
    prog.delete();
  endtask

  task automatic checkResetState(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d_%s_ready", d, tag), 32'(in_ready[d]), 32'd0);
      checkOutput($sformatf("dut%0d_%s_wb_valid", d, tag), 32'(wb_valid[d]), 32'd0);
      checkOutput($sformatf("dut%0d_%s_wb_rd", d, tag), 32'(wb_rd[d]), 32'd0);
      checkOutput($sformatf("dut%0d_%s_wb_data", d, tag), wb_data[d], 32'd0);
      checkOutput($sformatf("dut%0d_%s_retire", d, tag), retire_cnt[d], 32'd0);
      checkOutput($sformatf("dut%0d_%s_dbg", d, tag), dbg_data[d], 32'd0);
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    #1;
    checkResetState("por");
    @(negedge clk);
    rst = 1'b1;

    // single immediate add, then dbg read and retire count
    prog.delete();
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 16'd5));
    runProgram(1'b1);
    for (int d = 0; d < 2; d++) begin
      peekReg(d, 5'd1, 32'd5, "r1_after_add");
      checkOutput($sformatf("dut%0d_retire_one", d), retire_cnt[d], 32'd1);
    end

    // dependent chain: bypass has no stalls, interlock stalls two per dependency
    prog.delete();
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 16'd7));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd1, 5'd1, 5'd2, 1'b0, 16'd0));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd1, 5'd2, 5'd1, 5'd3, 1'b0, 16'd0));
    stall[0] = 0;
    stall[1] = 0;
    runProgram(1'b1);
    checkOutput("dut0_chain_stalls", 32'(stall[0]), 32'd0);
    checkOutput("dut1_chain_stalls", 32'(stall[1]), 32'd4);
    for (int d = 0; d < 2; d++) begin
      peekReg(d, 5'd1, 32'd7, "chain_r1");
      peekReg(d, 5'd2, 32'd14, "chain_r2");
      peekReg(d, 5'd3, 32'd7, "chain_r3");
    end

    // ALU corner results and a write aimed at r0
    prog.delete();
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd4, 1'b1, 16'hFFFF));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd5, 1'b1, 16'd1));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd5, 5'd4, 5'd5, 5'd6, 1'b0, 16'd0));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd6, 5'd5, 5'd0, 5'd7, 1'b1, 16'd31));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd7, 5'd0, 5'd0, 5'd8, 1'b0, 16'd0));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd1, 5'd0, 5'd5, 5'd9, 1'b0, 16'd0));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1, 16'd9));
    runProgram(1'b1);
    for (int d = 0; d < 2; d++) begin
      peekReg(d, 5'd6, 32'd1, "slt");
      peekReg(d, 5'd7, 32'h8000_0000, "sll");
      peekReg(d, 5'd8, 32'hFFFF_FFFF, "nor");
      peekReg(d, 5'd9, 32'hFFFF_FFFF, "sub");
      peekReg(d, 5'd0, 32'd0, "r0");
    end

    // three ops in flight then a flush with a valid op presented
    prog.delete();
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd10, 1'b1, 16'd1));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd11, 1'b1, 16'd2));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd12, 1'b1, 16'd3));
    prog.push_back(mkOp(1'b1, 1'b1, 3'd0, 5'd0, 5'd0, 5'd13, 1'b1, 16'd4));
    runProgram(1'b1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d_retire_after_flush", d), retire_cnt[d], 32'd11);
      peekReg(d, 5'd10, 32'd0, "flushed_r10");
      peekReg(d, 5'd12, 32'd0, "flushed_r12");
      peekReg(d, 5'd13, 32'd0, "flushed_r13");
    end

    // randomized traffic, stopped with ops still in flight
    prog.delete();
    for (int i = 0; i < 300; i++) prog.push_back(randOp());
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd2, 1'b1, 16'd3));
    prog.push_back(mkOp(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd3, 1'b1, 16'd4));
    runProgram(1'b0);

    // asynchronous reset between clock edges
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkResetState("midreset");
    clearModel();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // idle after release must produce no writeback, then more random traffic
    prog.delete();
    for (int i = 0; i < 5; i++)
      prog.push_back(mkOp(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 16'd0));
    for (int i = 0; i < 150; i++) prog.push_back(randOp());
    runProgram(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_pipe.md
# alu_issue_pipe

Parametrised integer issue/execute/writeback back-end for the pipelined CPU: it accepts decoded ALU operations over a valid/ready handshake, reads operands from an internal register file, executes, carries results through a configurable-depth pipeline and writes them back. It generalises the fixed ID→EX→MEM→WB datapath with selectable depth, data width, register count, a forwarding/interlock mode, flush, and a retire counter.

## Interface
- XLEN, 32, datapath width (≥16)
- NREG, 32, register count, power of two ≥4; RW = log2(NREG)
- STAGES, 3, result pipeline depth from issue to writeback (≥1)
- FWD, 1, 1 = full bypass from in-flight stages; 0 = scoreboard interlock only
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded op presented
- in_ready  out  1  op accepted this cycle when in_valid&in_ready
- in_aluctr  in  3  ALU operation
- in_rs, in_rt, in_rd  in  RW  source/destination register indices
- in_use_imm  in  1  second operand = sign-extended in_imm instead of reg[rt]
- in_imm  in  16  immediate
- flush  in  1  kill all in-flight ops
- wb_valid  out  1  writeback occurring this cycle
- wb_rd  out  RW  writeback register
- wb_data  out  XLEN  writeback value
- retire_cnt  out  32  count of completed writebacks
- dbg_addr  in  RW  debug read index
- dbg_data  out  XLEN  combinational register-file contents at dbg_addr (no bypass)

## Operation
- ALU codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1/0), 110 SLL (A << B[log2(XLEN)-1:0]), 111 NOR. Arithmetic modulo 2^XLEN, overflow ignored.
- A = operand(rs); B = in_use_imm ? sext(in_imm) : operand(rt).
- Register 0 reads zero always; ops with rd=0 flow through and retire (wb_valid=1, counted) but never modify reg 0.
- Pipeline registers P1..PSTAGES each hold {valid, rd, result}. Result computed combinationally at issue, captured into P1; shifts P(k)→P(k+1) every cycle, never stalls.
- wb_* mirror PSTAGES; register file written at the edge ending a cycle with wb_valid=1 and wb_rd≠0. Register file read is write-through: a same-cycle writeback to the read index returns wb_data.
- Operand resolution (rs/rt, index≠0): FWD=1 — youngest valid Pk (lowest k) with rd match supplies result, else register file; in_ready=1 always (unless reset). FWD=0 — hazard if any valid Pk, k<STAGES, matches a used source (rt ignored when in_use_imm); in_ready=!hazard; PSTAGES resolved by write-through.
- No issue (in_valid=0 or in_ready=0): bubble (valid=0) enters P1.
- flush=1: all Pk valid cleared at the edge, wb_valid forced 0 that cycle (PSTAGES write suppressed, not counted); in_ready=1 and any presented op is accepted and discarded.
- retire_cnt increments on every wb_valid cycle, wraps 2^32−1→0.

## Timing
- Reset (rst=0, asynchronous): all registers and Pk cleared, wb_valid=0, wb_rd=0, wb_data=0, retire_cnt=0, in_ready=0 while asserted. Reset mid-operation discards all in-flight ops.
- Latency: op accepted in cycle T → wb_valid in cycle T+STAGES → visible to dbg_data from cycle T+STAGES+1 (to issue via write-through at T+STAGES).
- FWD=1 back-to-back dependent ops issue every cycle, zero stalls.
- FWD=0 dependent op following producer at T stalls until cycle T+STAGES, i.e. STAGES−1 stall cycles.
- in_ready combinational from inputs and pipeline state; in_* must be held stable while in_valid=1 and in_ready=0.

## Test plan
- Reset, STAGES=3: after rst release, ADD r1=r0+imm 5 at T → wb_valid, wb_rd=1, wb_data=5 at T+3; dbg_addr=1 reads 5 at T+4; retire_cnt=1.
- FWD=1 chain: r1=7, r2=r1+r1, r3=r2−r1 issued on consecutive cycles → wb_data 7,14,7 on consecutive cycles, in_ready never 0.
- FWD=0, STAGES=3 same chain → in_ready low 2 cycles before each dependent op; identical results; total 3+2+2+3 cycles.
- ALU coverage XLEN=32: SLT(−1,1)=1, SLL(1,31)=0x80000000, NOR(0,0)=0xFFFFFFFF, SUB(0,1)=0xFFFFFFFF, write to r0 leaves dbg_data(0)=0.
- Flush: three ops in flight, flush=1 with in_valid=1 → no wb_valid for 3 cycles, registers unchanged, retire_cnt unchanged.
- Async reset asserted mid-stream between edges → outputs 0 immediately, no writeback after release until new issue.
